// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the wide-word SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Default geometry: a 32-bit CPU word over a 16-bit SRAM bus.
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DQ_W_DEF   = 16;
   localparam int unsigned BEATS      = DATA_W_DEF / DQ_W_DEF;
   localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

   // SRAM half-word address for one beat of a CPU word; wraps silently below base.
   function automatic logic [31:0] sram_word_addr(input logic [31:0] address,
                                                  input logic [31:0] beat,
                                                  input logic [31:0] base,
                                                  input int unsigned word_shift,
                                                  input int unsigned beats);
      logic [31:0] word_idx;
      word_idx = (address - base) >> word_shift;
      return (word_idx * beats) + beat;
   endfunction

endpackage

// File: rtl/sram_ctrl_wide_beat_timer.sv
// Beat sequencer: per-beat wait down-counter plus beat index.
module sram_beat_timer
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned N_BEATS  = BEATS,
   parameter int unsigned N_BEAT_W = BEAT_W,
   parameter int unsigned WAIT_CYC = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                run,
   output logic [N_BEAT_W-1:0] beat,
   output logic                beat_last_cyc,
   output logic                all_done
);

   localparam logic [3:0]          WAIT_LD  = 4'(WAIT_CYC);
   localparam logic [N_BEAT_W-1:0] BEAT_MAX = N_BEAT_W'(N_BEATS - 1);

   logic [3:0]          wait_q, wait_d;
   logic [N_BEAT_W-1:0] beat_q, beat_d;

   always_comb begin
      wait_d        = wait_q;
      beat_d        = beat_q;
      beat_last_cyc = run && (wait_q == 4'd0);
      all_done      = beat_last_cyc && (beat_q == BEAT_MAX);
      if (start) begin
         wait_d = WAIT_LD;
         beat_d = '0;
      end else if (run) begin
         if (wait_q == 4'd0) begin
            wait_d = WAIT_LD;
            beat_d = all_done ? '0 : beat_q + 1'b1;
         end else begin
            wait_d = wait_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q <= '0;
         beat_q <= '0;
      end else begin
         wait_q <= wait_d;
         beat_q <= beat_d;
      end
   end

   assign beat = beat_q;

endmodule

// File: rtl/sram_ctrl_wide.sv
// CPU word <-> narrow async SRAM bridge; each word is split into DATA_W/DQ_W beats.
// Optional one-entry read buffer enabled by defining SRAM_CTRL_RDBUF_EN.
module sram_ctrl_wide
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DQ_W      = 16,
   parameter int unsigned SRAM_AW   = 18,
   parameter logic [31:0] BASE_ADDR = 32'h400,
   parameter int unsigned WAIT_CYC  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic                rd_en,
   input  logic [31:0]         address,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic [DATA_W-1:0]   rd_data,
   output logic                ready,
   inout  wire  [DQ_W-1:0]     SRAM_DQ,
   output logic [SRAM_AW-1:0]  SRAM_ADDR,
   output logic                SRAM_UB_N,
   output logic                SRAM_LB_N,
   output logic                SRAM_WE_N,
   output logic                SRAM_CE_N,
   output logic                SRAM_OE_N
);

   localparam int unsigned N_BEATS    = DATA_W / DQ_W;
   localparam int unsigned N_BEAT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
   localparam int unsigned WORD_SHIFT = $clog2(DATA_W / 8);

   state_e state_q, state_d;
   logic                is_wr_q, is_wr_d;
   logic [31:0]         addr_q, addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [DATA_W/8-1:0] byte_en_q, byte_en_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   logic                accept, hit, timer_start;
   logic [DATA_W-1:0]   hit_data;
   logic [N_BEAT_W-1:0] beat;
   logic                beat_last_cyc, all_done;
   logic [DATA_W-1:0]   wr_shift;
   logic [DATA_W/8-1:0] be_shift;
   logic                we_n;

   assign timer_start = accept && !hit;

   sram_beat_timer #(
      .N_BEATS (N_BEATS),
      .N_BEAT_W(N_BEAT_W),
      .WAIT_CYC(WAIT_CYC)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .start        (timer_start),
      .run          (state_q == ACCESS),
      .beat         (beat),
      .beat_last_cyc(beat_last_cyc),
      .all_done     (all_done)
   );

`ifdef SRAM_CTRL_RDBUF_EN
   logic              buf_valid_q, buf_valid_d;
   logic [31:0]       buf_addr_q, buf_addr_d;
   logic [DATA_W-1:0] buf_data_q, buf_data_d;
   logic              buf_match;

   assign buf_match = buf_valid_q && (buf_addr_q == (address >> WORD_SHIFT));
   assign hit       = rd_en && !wr_en && buf_match;
   assign hit_data  = buf_data_q;

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      // Writes keep a buffered copy coherent instead of invalidating it.
      if (accept && wr_en && buf_match) begin
         for (int i = 0; i < DATA_W / 8; i++) begin
            if (byte_en[i]) buf_data_d[8*i +: 8] = wr_data[8*i +: 8];
         end
      end
      if (state_q == DONE && !is_wr_q) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = addr_q >> WORD_SHIFT;
         buf_data_d  = rd_data_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      byte_en_d = byte_en_q;
      rd_data_d = rd_data_q;
      ready     = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = !(wr_en || rd_en);
            if (wr_en || rd_en) begin
               accept    = 1'b1;
               is_wr_d   = wr_en;
               addr_d    = address;
               wr_data_d = wr_data;
               byte_en_d = byte_en;
               if (hit) begin
                  state_d   = DONE;
                  rd_data_d = hit_data;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!is_wr_q && beat_last_cyc) begin
               for (int b = 0; b < N_BEATS; b++) begin
                  if (beat == N_BEAT_W'(b)) rd_data_d[b*DQ_W +: DQ_W] = SRAM_DQ;
               end
            end
            if (all_done) state_d = DONE;
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         wr_data_q <= '0;
         byte_en_q <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         byte_en_q <= byte_en_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Decoded from the state flop so reset releases the bus asynchronously.
   assign we_n     = !(state_q == ACCESS && is_wr_q);
   assign wr_shift = wr_data_q >> (beat * DQ_W);
   assign be_shift = byte_en_q >> {beat, 1'b0};

   assign SRAM_DQ   = we_n ? {DQ_W{1'bz}} : wr_shift[DQ_W-1:0];
   assign SRAM_ADDR = SRAM_AW'(sram_word_addr(addr_q, 32'(beat), BASE_ADDR, WORD_SHIFT, N_BEATS));
   assign SRAM_LB_N = is_wr_q ? ~be_shift[0] : 1'b0;
   assign SRAM_UB_N = is_wr_q ? ~be_shift[1] : 1'b0;
   assign SRAM_WE_N = we_n;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign rd_data   = rd_data_q;

endmodule
